// File: rtl/risc_pkg.sv
// Shared constants for the risc core: datapath widths, instruction field
// positions, opcode encodings and the output-port register index.
package risc_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 24;
    localparam int RC_MSB = 23;
    localparam int RC_LSB = 16;
    localparam int RA_MSB = 15;
    localparam int RA_LSB = 8;
    localparam int RB_MSB = 7;
    localparam int RB_LSB = 0;

    typedef enum logic [7:0] {
        OP_ADD = 8'd0,
        OP_IMM = 8'd1
    } op_e;

    localparam logic [ADDR_W-1:0] OUT_IDX = 8'd255;

endpackage

// File: rtl/risc.sv
// Single-cycle accumulator-free RISC core: fetch, decode, execute and
// register write-back all happen in one clock from asynchronous-read memories.
module risc
    import risc_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              io_boot,
    input  logic [DATA_W-1:0] io_wrData,
    input  logic [ADDR_W-1:0] io_wrAddr,
    input  logic              io_isWr,
    output logic [DATA_W-1:0] io_out,
    output logic              io_valid
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [DATA_W-1:0] code_q [DEPTH];
    logic [DATA_W-1:0] file_q [DEPTH];

    logic [DATA_W-1:0] instr;
    logic [7:0]        op;
    logic [ADDR_W-1:0] rc;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic [DATA_W-1:0] result;
    logic              exec;
    logic              rf_we;

    assign instr = code_q[pc_q];
    assign op    = instr[OP_MSB:OP_LSB];
    assign rc    = instr[RC_MSB:RC_LSB];
    assign ra    = instr[RA_MSB:RA_LSB];
    assign rb    = instr[RB_MSB:RB_LSB];

    // Register 0 may be written but always reads back as zero.
    assign val_a = (ra == '0) ? '0 : file_q[ra];
    assign val_b = (rb == '0) ? '0 : file_q[rb];

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = val_a + val_b;
            OP_IMM:  result = {{(DATA_W-2*ADDR_W){1'b0}}, ra, rb};
            default: result = '0;
        endcase
    end

    // Reset, code writes and boot all suppress execution for the cycle.
    assign exec     = !reset && !io_isWr && !io_boot;
    assign io_out   = exec ? result : '0;
    assign io_valid = exec && (rc == OUT_IDX);
    assign rf_we    = exec && (rc != OUT_IDX);

    always_comb begin
        pc_d = pc_q + ADDR_W'(1);
        if (io_isWr) begin
            pc_d = pc_q;
        end else if (io_boot) begin
            pc_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Memories carry no reset; their contents are defined only once written.
    always_ff @(posedge clock) begin
        if (!reset && io_isWr) begin
            code_q[io_wrAddr] <= io_wrData;
        end
        if (rf_we) begin
            file_q[rc] <= result;
        end
    end

endmodule

// File: tb/tb_risc.sv
// Self-checking bench for risc: directed scenarios plus randomized programs
// compared cycle by cycle against an instruction-level reference model.
module tb_risc;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_boot;
    logic [31:0] io_wrData;
    logic [7:0]  io_wrAddr;
    logic        io_isWr;
    logic [31:0] io_out;
    logic        io_valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_code [256];
    logic [31:0] m_file [256];
    int          m_pc = 0;

    always #5 clock = ~clock;

    risc dut (
        .clock     (clock),
        .reset     (reset),
        .io_boot   (io_boot),
        .io_wrData (io_wrData),
        .io_wrAddr (io_wrAddr),
        .io_isWr   (io_isWr),
        .io_out    (io_out),
        .io_valid  (io_valid)
    );

    // Architectural model: what the current cycle should output.
    function automatic void predict(output logic [31:0] o, output logic v);
        longint w, op, rc, ra, rb, a, b;
        o = 32'd0;
        v = 1'b0;
        if (reset || io_isWr || io_boot) return;
        w  = longint'(m_code[m_pc]);
        op = w >> 24;
        rc = (w >> 16) % 256;
        ra = (w >> 8) % 256;
        rb = w % 256;
        a  = (ra == 0) ? 0 : longint'(m_file[int'(ra)]);
        b  = (rb == 0) ? 0 : longint'(m_file[int'(rb)]);
        if (op == 0)      o = 32'((a + b) % 64'h1_0000_0000);
        else if (op == 1) o = 32'(ra * 256 + rb);
        v = (rc == 255);
    endfunction

    // Advance the model by one cycle with the current inputs, then clock the DUT.
    task automatic tick();
        logic [31:0] o;
        logic        v;
        int          rc;
        predict(o, v);
        if (reset) begin
            m_pc = 0;
        end else if (io_isWr) begin
            m_code[io_wrAddr] = io_wrData;
        end else if (io_boot) begin
            m_pc = 0;
        end else begin
            rc = int'((m_code[m_pc] >> 16) & 32'hFF);
            if (rc != 255) m_file[rc] = o;
            m_pc = (m_pc + 1) % 256;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic wr, input logic boot, input logic [31:0] d, input logic [7:0] a);
        io_isWr   = wr;
        io_boot   = boot;
        io_wrData = d;
        io_wrAddr = a;
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, d, a);
        tick();
    endtask

    task automatic boot_cycle();
        drive(1'b0, 1'b1, 32'd0, 8'd0);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h01FF_0042, 8'd0);
        #1;
        checks++;
        if (io_out !== 32'd0 || io_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_with_wr: out=%h valid=%b, expected out=0 valid=0", io_out, io_valid);
        end
        tick();
        drive(1'b0, 1'b0, 32'd0, 8'd0);
        #1;
        checks++;
        if (io_out !== 32'd0 || io_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: out=%h valid=%b, expected out=0 valid=0", io_out, io_valid);
        end
        tick();
        reset = 1'b0;
    endtask

    // Loads 256 IMM instructions writing every register, then runs past the wrap.
    task automatic test_fill_wrap();
        logic [31:0] eo;
        logic        ev;
        for (int i = 0; i < 256; i++) load(8'(i), {8'h01, 8'(i), 16'($urandom)});
        boot_cycle();
        drive(1'b0, 1'b0, 32'd0, 8'd0);
        for (int i = 0; i < 257; i++) begin
            #1;
            predict(eo, ev);
            checks++;
            if (io_out !== eo || io_valid !== ev) begin
                errors++;
                $display("FAIL fill_step%0d: out=%h valid=%b, expected out=%h valid=%b", i, io_out, io_valid, eo, ev);
            end
            tick();
        end
    endtask

    task automatic test_reset_priority();
        logic [31:0] eo;
        logic        ev;
        drive(1'b0, 1'b0, 32'd0, 8'd0);
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        drive(1'b1, 1'b1, 32'h01FF_BEEF, 8'd0);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 8'd0);
        #1;
        predict(eo, ev);
        checks++;
        if (io_out !== eo || io_valid !== ev) begin
            errors++;
            $display("FAIL reset_priority: out=%h valid=%b, expected out=%h valid=%b", io_out, io_valid, eo, ev);
        end
        tick();
    endtask

    task automatic test_program();
        load(8'd0, 32'h0101_0001);
        load(8'd1, 32'h0001_0101);
        load(8'd2, 32'h0001_0101);
        load(8'd3, 32'h00FF_0100);
        boot_cycle();
        drive(1'b0, 1'b0, 32'd0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (io_valid !== 1'b0) begin
                errors++;
                $display("FAIL program_step%0d: valid=%b, expected valid=0", i, io_valid);
            end
            tick();
        end
        #1;
        checks++;
        if (io_out !== 32'd4 || io_valid !== 1'b1) begin
            errors++;
            $display("FAIL program_result: out=%h valid=%b, expected out=4 valid=1", io_out, io_valid);
        end
        tick();
    endtask

    task automatic test_imm_out();
        load(8'd0, 32'h01FF_1234);
        boot_cycle();
        drive(1'b0, 1'b0, 32'd0, 8'd0);
        #1;
        checks++;
        if (io_out !== 32'h0000_1234 || io_valid !== 1'b1) begin
            errors++;
            $display("FAIL imm_out: out=%h valid=%b, expected out=00001234 valid=1", io_out, io_valid);
        end
        tick();
    endtask

    task automatic test_add_wrap();
        logic [31:0] prog [$];
        prog.push_back(32'h0101_FFFF);
        prog.push_back(32'h0103_FFFF);
        for (int i = 0; i < 16; i++) prog.push_back(32'h0001_0101);
        prog.push_back(32'h0001_0103);
        prog.push_back(32'h00FF_0100);
        prog.push_back(32'h0102_0001);
        prog.push_back(32'h00FF_0102);
        foreach (prog[i]) load(8'(i), prog[i]);
        boot_cycle();
        drive(1'b0, 1'b0, 32'd0, 8'd0);
        for (int i = 0; i < prog.size(); i++) begin
            #1;
            if (i == 19) begin
                checks++;
                if (io_out !== 32'hFFFF_FFFF || io_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL add_all_ones: out=%h valid=%b, expected out=ffffffff valid=1", io_out, io_valid);
                end
            end
            if (i == 21) begin
                checks++;
                if (io_out !== 32'd0 || io_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL add_wrap: out=%h valid=%b, expected out=0 valid=1", io_out, io_valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_r0();
        load(8'd0, 32'h0100_0005);
        load(8'd1, 32'h00FF_0000);
        boot_cycle();
        drive(1'b0, 1'b0, 32'd0, 8'd0);
        #1;
        checks++;
        if (io_out !== 32'd5 || io_valid !== 1'b0) begin
            errors++;
            $display("FAIL r0_write: out=%h valid=%b, expected out=5 valid=0", io_out, io_valid);
        end
        tick();
        #1;
        checks++;
        if (io_out !== 32'd0 || io_valid !== 1'b1) begin
            errors++;
            $display("FAIL r0_read: out=%h valid=%b, expected out=0 valid=1", io_out, io_valid);
        end
        tick();
    endtask

    task automatic test_wr_boot();
        load(8'd0, 32'h01FF_000A);
        load(8'd1, 32'h01FF_000B);
        load(8'd2, 32'h01FF_000C);
        load(8'd3, 32'h01FF_000D);
        boot_cycle();
        drive(1'b0, 1'b0, 32'd0, 8'd0);
        tick();
        tick();
        drive(1'b1, 1'b1, 32'h01FF_00EE, 8'd0);
        #1;
        checks++;
        if (io_out !== 32'd0 || io_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_and_boot: out=%h valid=%b, expected out=0 valid=0", io_out, io_valid);
        end
        tick();
        drive(1'b0, 1'b0, 32'd0, 8'd0);
        #1;
        checks++;
        if (io_out !== 32'h0000_000C || io_valid !== 1'b1) begin
            errors++;
            $display("FAIL pc_held: out=%h valid=%b, expected out=0000000c valid=1", io_out, io_valid);
        end
        tick();
        drive(1'b0, 1'b1, 32'd0, 8'd0);
        #1;
        checks++;
        if (io_out !== 32'd0 || io_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_cycle: out=%h valid=%b, expected out=0 valid=0", io_out, io_valid);
        end
        tick();
        drive(1'b0, 1'b0, 32'd0, 8'd0);
        #1;
        checks++;
        if (io_out !== 32'h0000_00EE || io_valid !== 1'b1) begin
            errors++;
            $display("FAIL boot_refetch: out=%h valid=%b, expected out=000000ee valid=1", io_out, io_valid);
        end
        tick();
    endtask

    task automatic test_wrap_undefined();
        load(8'd254, 32'h01FF_00FE);
        load(8'd255, 32'h01FF_00FF);
        load(8'd0,   32'h07FF_1234);
        boot_cycle();
        drive(1'b0, 1'b0, 32'd0, 8'd0);
        for (int i = 0; i < 254; i++) tick();
        #1;
        checks++;
        if (io_out !== 32'h0000_00FE || io_valid !== 1'b1) begin
            errors++;
            $display("FAIL pc_254: out=%h valid=%b, expected out=000000fe valid=1", io_out, io_valid);
        end
        tick();
        #1;
        checks++;
        if (io_out !== 32'h0000_00FF || io_valid !== 1'b1) begin
            errors++;
            $display("FAIL pc_255: out=%h valid=%b, expected out=000000ff valid=1", io_out, io_valid);
        end
        tick();
        #1;
        checks++;
        if (io_out !== 32'd0 || io_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_undef_op: out=%h valid=%b, expected out=0 valid=1", io_out, io_valid);
        end
        tick();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [7:0] op, rc;
        int         sel;
        sel = $urandom_range(0, 9);
        if (sel < 5)      op = 8'd0;
        else if (sel < 8) op = 8'd1;
        else              op = 8'($urandom_range(2, 255));
        rc = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
        return {op, rc, 8'($urandom), 8'($urandom)};
    endfunction

    task automatic test_random();
        logic [31:0] eo;
        logic        ev;
        int          sel;
        for (int i = 0; i < 256; i++) load(8'(i), rand_instr());
        boot_cycle();
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 99);
            reset = (sel == 0);
            if (sel < 6)       drive(1'b1, sel[0], rand_instr(), 8'($urandom));
            else if (sel < 9)  drive(1'b0, 1'b1, 32'd0, 8'd0);
            else               drive(1'b0, 1'b0, 32'd0, 8'd0);
            #1;
            predict(eo, ev);
            checks++;
            if (io_out !== eo || io_valid !== ev) begin
                errors++;
                $display("FAIL random_step%0d: out=%h valid=%b, expected out=%h valid=%b", i, io_out, io_valid, eo, ev);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 8'd0);
        @(negedge clock);
        test_reset();
        test_fill_wrap();
        test_reset_priority();
        test_program();
        test_imm_out();
        test_add_wrap();
        test_r0();
        test_wr_boot();
        test_wrap_undefined();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
